genexu_mul_div_dispatch: RTL and testbench
==========================================

Name: genexu_mul_div_dispatch

Overview:
- Pipeline-side initiator for the MUL/DIV execution unit's genfifo stream protocol.
- Accepts issued M-extension ops from the core, drives the request stream (instr_code, src0_data, src1_data) and consumes the response stream (rd0_wdata).
- Tracks the destination register of every in-flight op in an in-order tag FIFO and produces a registered register-file writeback.
- Supports pipeline flush with kill of outstanding results.

Parameters:
MAX_OUTSTANDING, 2, tag FIFO depth / max accepted-but-unanswered ops; power of two, >=1
TIMEOUT_CYCLES, 64, watchdog limit (used only with optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
issue_valid_i  in  1  core presents an op
issue_ready_o  out  1  dispatcher can capture op
issue_instr_i  in  32  instruction word (funct3 in [14:12])
issue_src0_i  in  32  rs1 value
issue_src1_i  in  32  rs2 value
issue_rd_i  in  5  destination register
flush_i  in  1  discard unsent op, kill outstanding results
stream_req_bus_genfifo_req_o  out  1  request valid
stream_req_bus_genfifo_wdata_bo  out  req_struct  {instr_code, src0_data, src1_data}
stream_req_bus_genfifo_ack_i  in  1  EXU accepts request
stream_resp_bus_genfifo_req_i  in  1  response valid
stream_resp_bus_genfifo_rdata_bi  in  resp_struct  {rd0_wdata}
stream_resp_bus_genfifo_ack_o  out  1  dispatcher accepts response
wb_valid_o  out  1  writeback strobe
wb_rd_o  out  5  writeback register
wb_data_o  out  32  writeback data
busy_o  out  1  unsent op held or tag FIFO non-empty
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i low, async): state IDLE, FIFO empty, all outputs 0 (req_o, ack_o, wb_*, busy_o, err_o, issue_ready_o).
- Transfer rule (both streams): transfer iff req && ack in same rising edge.
- Request FSM, IDLE / SEND:
  - IDLE: issue_ready_o = (count < MAX_OUTSTANDING) && !flush_i. On issue_valid_i && issue_ready_o, capture instr/src0/src1/rd into hold regs and go to SEND.
  - SEND: req_o = 1. wdata_bo comes from hold regs and stays stable until transfer. On ack_i, push {kill=0, rd} into the FIFO and return to IDLE. No back-to-back capture in the transfer cycle: at most one issue per 2 cycles.
- Tag FIFO: pointers wrap modulo MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.
  - Simultaneous push and pop are allowed; count is unchanged.
  - Overflow cannot occur because capture is gated by count.
- Response:
  - ack_o = FIFO non-empty (no backpressure).
  - On transfer, pop the head.
  - If head.kill=0 and head.rd!=0: next cycle wb_valid_o=1 with wb_rd_o=head.rd and wb_data_o=rd0_wdata (latency 1). Otherwise wb_valid_o stays 0.
  - wb_valid_o is a single-cycle pulse; wb_rd_o/wb_data_o hold their last values.
- Response while FIFO empty: ack_o=0 and err_o set (sticky until reset).
- Flush (flush_i=1 in cycle N):
  - Every FIFO entry gets kill=1.
  - SEND with no ack_i in N: hold dropped, state IDLE, req_o=0 in N+1.
  - SEND with ack_i in N: op already transferred, pushed with kill=1.
  - Response popped in N: its wb is suppressed.
- busy_o = (state==SEND) || count!=0.

Optional Feature:
GENEXU_MUL_DIV_DISPATCH_TIMEOUT_EN:
- Defined: a counter increments each cycle with count!=0 and no response transfer; it clears on response transfer or when count==0. On reaching TIMEOUT_CYCLES it sets err_o, flushes the FIFO to empty, and forces ack_o=0 until a new push.
- Undefined: no counter; err_o only reports unexpected responses.

Test Plan:
- MUL: issue instr funct3=0, src0=7, src1=6, rd=5; EXU ack after 1 cycle, resp 2 cycles later with 42 -> wb_valid_o pulse one cycle after resp transfer with rd=5, data=42, busy_o then 0.
- Backpressure: ack_i held 0 for 10 cycles -> req_o=1, wdata_bo constant, issue_ready_o=0 throughout, transfer on cycle 11.
- Fill: MAX_OUTSTANDING=2, two ops acked (rd=1, rd=2), no responses -> issue_ready_o=0; responses 0x11 and 0x22 -> writebacks in order rd1=0x11 then rd2=0x22.
- Flush with one outstanding (rd=3) and one unsent -> req_o drops next cycle, later response acked but no wb_valid_o, busy_o returns 0.
- rd=0 op (DIV 100/7) -> response acked, no writeback. An unsolicited resp_req_i while idle -> ack_o=0, err_o=1 until reset.
- TIMEOUT_EN, TIMEOUT_CYCLES=64: op acked, no response -> err_o=1 at cycle 64 after ack, FIFO empty, busy_o=0.

Source files
------------

// File: rtl/genexu_mul_div_dispatch.sv
// Pipeline-side initiator for the MUL/DIV genfifo streams: issues ops, tracks rd tags in order, retires writebacks.
// Optional watchdog on unanswered ops: define GENEXU_MUL_DIV_DISPATCH_TIMEOUT_EN.
package genexu_mul_div_dispatch_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr_code;
    logic [XLEN-1:0] src0_data;
    logic [XLEN-1:0] src1_data;
  } req_struct;

  typedef struct packed {
    logic [XLEN-1:0] rd0_wdata;
  } resp_struct;
endpackage

module genexu_mul_div_dispatch
  import genexu_mul_div_dispatch_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [XLEN-1:0] issue_instr_i,
  input  logic [XLEN-1:0] issue_src0_i,
  input  logic [XLEN-1:0] issue_src1_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            flush_i,
  output logic            stream_req_bus_genfifo_req_o,
  output req_struct       stream_req_bus_genfifo_wdata_bo,
  input  logic            stream_req_bus_genfifo_ack_i,
  input  logic            stream_resp_bus_genfifo_req_i,
  input  resp_struct      stream_resp_bus_genfifo_rdata_bi,
  output logic            stream_resp_bus_genfifo_ack_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  if (MAX_OUTSTANDING == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("genexu_mul_div_dispatch: MAX_OUTSTANDING and TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              rst_done_q;
  req_struct         hold_q;
  logic [RD_W-1:0]   hold_rd_q;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [RD_W-1:0]   rd_mem_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] kill_q;

  logic              issue_fire;
  logic              push;
  logic              pop;
  logic              to_fire;
  logic [RD_W-1:0]   head_rd;
  logic              head_kill;
  logic              wb_fire;

  logic              wb_valid_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request FSM state register; rst_done_q keeps issue_ready_o low while in reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next-state and request-side outputs.
  always_comb begin
    state_d                      = state_q;
    issue_ready_o                = 1'b0;
    stream_req_bus_genfifo_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_ready_o = rst_done_q && !flush_i && (count_q < CNT_W'(MAX_OUTSTANDING));
        if (issue_valid_i && issue_ready_o) state_d = SEND;
      end
      SEND: begin
        stream_req_bus_genfifo_req_o = 1'b1;
        if (stream_req_bus_genfifo_ack_i || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_fire = issue_valid_i && issue_ready_o;
  assign push       = (state_q == SEND) && stream_req_bus_genfifo_ack_i;
  assign pop        = stream_resp_bus_genfifo_req_i && stream_resp_bus_genfifo_ack_o;
  assign head_rd    = rd_mem_q[rd_ptr_q];
  assign head_kill  = kill_q[rd_ptr_q];
  assign wb_fire    = pop && !head_kill && !flush_i && (head_rd != '0);

  // Hold registers drive the request payload until it is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_q    <= '0;
      hold_rd_q <= '0;
    end else if (issue_fire) begin
      hold_q.instr_code <= issue_instr_i;
      hold_q.src0_data  <= issue_src0_i;
      hold_q.src1_data  <= issue_src1_i;
      hold_rd_q         <= issue_rd_i;
    end
  end

  assign stream_req_bus_genfifo_wdata_bo = hold_q;

  // In-order tag FIFO; flush marks every live entry (and a same-cycle push) as killed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      kill_q   <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) rd_mem_q[i] <= '0;
    end else begin
      if (flush_i) kill_q <= '1;
      if (push) begin
        rd_mem_q[wr_ptr_q] <= hold_rd_q;
        kill_q[wr_ptr_q]   <= flush_i;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (to_fire) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= push ? CNT_W'(1) : '0;
      end else if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

`ifdef GENEXU_MUL_DIV_DISPATCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign to_fire = (count_q != '0) && !pop && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent waiting on the oldest outstanding response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_q <= '0;
    end else if ((count_q == '0) || pop || to_fire) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Registered writeback; rd/data hold their last value between pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= wb_fire;
      if (wb_fire) begin
        wb_rd_q   <= head_rd;
        wb_data_q <= stream_resp_bus_genfifo_rdata_bi.rd0_wdata;
      end
      if ((stream_resp_bus_genfifo_req_i && (count_q == '0)) || to_fire) err_q <= 1'b1;
    end
  end

  assign stream_resp_bus_genfifo_ack_o = (count_q != '0);
  assign busy_o     = (state_q == SEND) || (count_q != '0);
  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_genexu_mul_div_dispatch.sv
// Directed bench for genexu_mul_div_dispatch: vector table for a full MUL round trip plus hand sequences.
module tb_genexu_mul_div_dispatch;
  import genexu_mul_div_dispatch_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [31:0] issue_src0_i;
  logic [31:0] issue_src1_i;
  logic [4:0]  issue_rd_i;
  logic        flush_i;
  logic        req_o;
  req_struct   wdata_bo;
  logic        req_ack_i;
  logic        resp_req_i;
  resp_struct  rdata_bi;
  logic        resp_ack_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        busy_o;
  logic        err_o;

  localparam logic [31:0] MUL_I  = 32'h0262_82B3;
  localparam logic [31:0] DIV_I  = 32'h0262_C233;
  localparam logic [31:0] DIV_X0 = 32'h0270_4033;

  genexu_mul_div_dispatch #(.MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(64)) dut (
    .clk_i                            (clk_i),
    .rst_i                            (rst_i),
    .issue_valid_i                    (issue_valid_i),
    .issue_ready_o                    (issue_ready_o),
    .issue_instr_i                    (issue_instr_i),
    .issue_src0_i                     (issue_src0_i),
    .issue_src1_i                     (issue_src1_i),
    .issue_rd_i                       (issue_rd_i),
    .flush_i                          (flush_i),
    .stream_req_bus_genfifo_req_o     (req_o),
    .stream_req_bus_genfifo_wdata_bo  (wdata_bo),
    .stream_req_bus_genfifo_ack_i     (req_ack_i),
    .stream_resp_bus_genfifo_req_i    (resp_req_i),
    .stream_resp_bus_genfifo_rdata_bi (rdata_bi),
    .stream_resp_bus_genfifo_ack_o    (resp_ack_o),
    .wb_valid_o                       (wb_valid_o),
    .wb_rd_o                          (wb_rd_o),
    .wb_data_o                        (wb_data_o),
    .busy_o                           (busy_o),
    .err_o                            (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [4:0]  rd;
    logic        ack;
    logic        rreq;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_rack;
    logic        e_wbv;
    logic [4:0]  e_wbrd;
    logic [31:0] e_wbdata;
    logic        e_busy;
    logic        e_err;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [9];
  int n_checks;
  int n_errors;

  function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [4:0] rd, input logic ack,
                              input logic rreq, input logic [31:0] rdata, input logic e_req,
                              input logic e_rack, input logic e_wbv, input logic [4:0] e_wbrd,
                              input logic [31:0] e_wbdata, input logic e_busy, input logic e_err,
                              input logic e_rdy);
    vec_t v;
    v.iv = iv; v.instr = instr; v.s0 = s0; v.s1 = s1; v.rd = rd; v.ack = ack;
    v.rreq = rreq; v.rdata = rdata; v.e_req = e_req; v.e_rack = e_rack; v.e_wbv = e_wbv;
    v.e_wbrd = e_wbrd; v.e_wbdata = e_wbdata; v.e_busy = e_busy; v.e_err = e_err; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [4:0] rd);
    issue_valid_i = 1'b1;
    issue_instr_i = ins;
    issue_src0_i  = s0;
    issue_src1_i  = s1;
    issue_rd_i    = rd;
    #1;
    chk("issue_ready", issue_ready_o, 1);
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic ack_op();
    req_ack_i = 1'b1;
    #1;
    chk("ack_req", req_o, 1);
    step();
    req_ack_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic exp_wb, input logic [4:0] rd);
    resp_req_i = 1'b1;
    rdata_bi.rd0_wdata = data;
    #1;
    chk("resp_ack", resp_ack_o, 1);
    step();
    resp_req_i = 1'b0;
    #1;
    chk("resp_wb_valid", wb_valid_o, exp_wb);
    if (exp_wb) begin
      chk("resp_wb_rd", wb_rd_o, rd);
      chk("resp_wb_data", wb_data_o, data);
    end
    step();
  endtask

  initial begin
    logic [95:0] exp_wd;
    n_checks = 0;
    n_errors = 0;
    exp_wd = '0;
    rst_i = 1'b0;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_src0_i = '0; issue_src1_i = '0;
    issue_rd_i = '0; flush_i = 1'b0; req_ack_i = 1'b0; resp_req_i = 1'b0; rdata_bi = '0;

    //             iv instr  s0 s1 rd ack rq rdata | req rack wbv wbrd wbdata busy err rdy
    vecs[0] = mk(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0,  0, 0, 1);
    vecs[1] = mk(1, MUL_I, 7, 6, 5, 0, 0, 0,    0, 0, 0, 0, 0,  0, 0, 1);
    vecs[2] = mk(0, 0,     0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,  1, 0, 0);
    vecs[3] = mk(0, 0,     0, 0, 0, 1, 0, 0,    1, 0, 0, 0, 0,  1, 0, 0);
    vecs[4] = mk(0, 0,     0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0,  1, 0, 1);
    vecs[5] = mk(0, 0,     0, 0, 0, 0, 0, 0,    0, 1, 0, 0, 0,  1, 0, 1);
    vecs[6] = mk(0, 0,     0, 0, 0, 0, 1, 42,   0, 1, 0, 0, 0,  1, 0, 1);
    vecs[7] = mk(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1, 5, 42, 0, 0, 1);
    vecs[8] = mk(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 0, 5, 42, 0, 0, 1);

    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_ready", issue_ready_o, 0);
    chk("rst_req", req_o, 0);
    chk("rst_wdata", wdata_bo, 0);
    chk("rst_resp_ack", resp_ack_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b1;
    step();

    // MUL round trip, one row per cycle
    for (int k = 0; k < 9; k++) begin
      issue_valid_i = vecs[k].iv;
      issue_instr_i = vecs[k].instr;
      issue_src0_i  = vecs[k].s0;
      issue_src1_i  = vecs[k].s1;
      issue_rd_i    = vecs[k].rd;
      req_ack_i     = vecs[k].ack;
      resp_req_i    = vecs[k].rreq;
      rdata_bi.rd0_wdata = vecs[k].rdata;
      if (vecs[k].iv) exp_wd = {vecs[k].instr, vecs[k].s0, vecs[k].s1};
      #1;
      chk("vec_req", req_o, vecs[k].e_req);
      if (vecs[k].e_req) chk("vec_wdata", wdata_bo, exp_wd);
      chk("vec_resp_ack", resp_ack_o, vecs[k].e_rack);
      chk("vec_wb_valid", wb_valid_o, vecs[k].e_wbv);
      chk("vec_wb_rd", wb_rd_o, vecs[k].e_wbrd);
      chk("vec_wb_data", wb_data_o, vecs[k].e_wbdata);
      chk("vec_busy", busy_o, vecs[k].e_busy);
      chk("vec_err", err_o, vecs[k].e_err);
      chk("vec_ready", issue_ready_o, vecs[k].e_rdy);
      step();
    end

    // Backpressure: request held stable for 10 cycles, accepted on the 11th
    issue(DIV_I, 32'hAAAA_0000, 32'h0000_5555, 4);
    for (int i = 0; i < 10; i++) begin
      req_ack_i = 1'b0;
      #1;
      chk("bp_req", req_o, 1);
      chk("bp_wdata", wdata_bo, {DIV_I, 32'hAAAA_0000, 32'h0000_5555});
      chk("bp_ready", issue_ready_o, 0);
      step();
    end
    ack_op();
    #1;
    chk("bp_req_drop", req_o, 0);
    chk("bp_outstanding", resp_ack_o, 1);
    respond(32'h1234, 1, 4);

    // Fill both tag slots, then retire in order
    issue(MUL_I, 1, 1, 1);
    ack_op();
    issue(MUL_I, 2, 2, 2);
    ack_op();
    #1;
    chk("fill_ready", issue_ready_o, 0);
    chk("fill_busy", busy_o, 1);
    issue_valid_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    #1;
    chk("fill_no_capture", req_o, 0);
    resp_req_i = 1'b1;
    rdata_bi.rd0_wdata = 32'h11;
    step();
    rdata_bi.rd0_wdata = 32'h22;
    #1;
    chk("fill_wb1_valid", wb_valid_o, 1);
    chk("fill_wb1_rd", wb_rd_o, 1);
    chk("fill_wb1_data", wb_data_o, 32'h11);
    step();
    resp_req_i = 1'b0;
    #1;
    chk("fill_wb2_valid", wb_valid_o, 1);
    chk("fill_wb2_rd", wb_rd_o, 2);
    chk("fill_wb2_data", wb_data_o, 32'h22);
    chk("fill_busy_done", busy_o, 0);
    step();
    #1;
    chk("fill_wb_pulse", wb_valid_o, 0);

    // Flush with one outstanding and one unsent op
    issue(MUL_I, 0, 0, 3);
    ack_op();
    issue(MUL_I, 0, 0, 6);
    flush_i = 1'b1;
    #1;
    chk("flush_ready", issue_ready_o, 0);
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_req_drop", req_o, 0);
    chk("flush_busy", busy_o, 1);
    respond(32'h99, 0, 0);
    chk("flush_busy_done", busy_o, 0);

    // Flush in the same cycle the request is accepted
    issue(MUL_I, 0, 0, 7);
    req_ack_i = 1'b1;
    flush_i = 1'b1;
    step();
    req_ack_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_ack_busy", busy_o, 1);
    respond(32'h77, 0, 0);

    // Flush in IDLE blocks capture; flush during pop suppresses writeback
    issue_valid_i = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush_idle_ready", issue_ready_o, 0);
    step();
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_idle_req", req_o, 0);
    issue(MUL_I, 0, 0, 8);
    ack_op();
    resp_req_i = 1'b1;
    flush_i = 1'b1;
    rdata_bi.rd0_wdata = 32'h55;
    step();
    resp_req_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_pop_wb", wb_valid_o, 0);
    chk("flush_pop_busy", busy_o, 0);
    step();

    // rd=0 DIV: accepted, no writeback, previous wb values held
    issue(DIV_X0, 100, 7, 0);
    ack_op();
    respond(14, 0, 0);
    chk("rd0_wb_rd_hold", wb_rd_o, 2);
    chk("rd0_wb_data_hold", wb_data_o, 32'h22);
    chk("rd0_busy", busy_o, 0);

    // Unsolicited response while idle
    resp_req_i = 1'b1;
    rdata_bi.rd0_wdata = 32'hDEAD;
    #1;
    chk("unsol_ack", resp_ack_o, 0);
    chk("unsol_err_pre", err_o, 0);
    step();
    resp_req_i = 1'b0;
    #1;
    chk("unsol_err", err_o, 1);
    repeat (3) step();
    chk("unsol_err_sticky", err_o, 1);
    rst_i = 1'b0;
    #1;
    chk("unsol_err_reset", err_o, 0);
    step();
    rst_i = 1'b1;
    step();

`ifdef GENEXU_MUL_DIV_DISPATCH_TIMEOUT_EN
    // Watchdog: 64 cycles after acceptance with no response
    issue(MUL_I, 1, 2, 9);
    ack_op();
    for (int i = 1; i < 64; i++) step();
    #1;
    chk("to_err_early", err_o, 0);
    chk("to_busy_early", busy_o, 1);
    step();
    #1;
    chk("to_err", err_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_resp_ack", resp_ack_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
